mem_access: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline. Sits between the ex_mem and mem_wb pipeline registers.
- Consumes the memory request produced by EX: op, address, store data, access size and extension mode.
- Performs each load/store as a byte-serial transfer on the shared 8-bit RAM port, through the memory controller's req/gnt arbitration.
- Holds the pipeline via stall_req_o until the transfer completes. Non-memory results pass straight through.

---
 rtl/mem_access_pkg.sv | 34 +++
 rtl/mem_access_if.sv | 14 +
 rtl/mem_access_load_ext.sv | 26 ++
 rtl/mem_access.sv | 137 +++++++++++++
 tb/tb_mem_access.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the RV32I MEM stage: memory ops, access sizes,
// load extension modes and the byte-serial transfer FSM states.
package mem_access_pkg;

   localparam logic [1:0] MemDisable  = 2'b00;
   localparam logic [1:0] MemRead     = 2'b01;
   localparam logic [1:0] MemWrite    = 2'b10;

   localparam logic [1:0] MemSelEmpty = 2'd0;
   localparam logic [1:0] MemSelByte  = 2'd1;
   localparam logic [1:0] MemSelHalf  = 2'd2;
   localparam logic [1:0] MemSelWord  = 2'd3;

   localparam logic       SEXT        = 1'b0;
   localparam logic       UEXT        = 1'b1;

   typedef enum logic [1:0] {
      MS_IDLE  = 2'd0,
      MS_XFER  = 2'd1,
      MS_RWAIT = 2'd2,
      MS_DONE  = 2'd3
   } mstate_t;

   // Number of bytes moved on the 8-bit RAM port for a given access size.
   function automatic logic [2:0] byte_count(input logic [1:0] sel);
      case (sel)
         MemSelByte: return 3'd1;
         MemSelHalf: return 3'd2;
         MemSelWord: return 3'd4;
         default:    return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide shared RAM port with req/gnt arbitration to the memory controller.
interface mem_access_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              gnt;
   logic [ADDR_W-1:0] a;
   logic [7:0]        dout;
   logic              wr;
   logic [7:0]        din;

   modport master (output req, a, dout, wr, input gnt, din);
   modport slave  (input req, a, dout, wr, output gnt, din);
endinterface

// File: rtl/mem_access_load_ext.sv
// Combinational size/sign extender for assembled load data.
module mem_access_load_ext
   import mem_access_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_buf,
   input  logic [1:0]        i_sel,
   input  logic              i_ext,
   output logic [DATA_W-1:0] o_wdata
);
   logic w_sb;
   logic w_sh;

   assign w_sb = (i_ext == SEXT) & i_buf[7];
   assign w_sh = (i_ext == SEXT) & i_buf[15];

   always_comb begin
      o_wdata = i_buf;
      case (i_sel)
         MemSelByte: o_wdata = {{(DATA_W-8){w_sb}},  i_buf[7:0]};
         MemSelHalf: o_wdata = {{(DATA_W-16){w_sh}}, i_buf[15:0]};
         default:    o_wdata = i_buf;
      endcase
   end
endmodule

// File: rtl/mem_access.sv
// MEM stage: runs each load/store as a byte-serial transfer on the shared RAM
// port and stalls the pipeline until the result is ready for mem_wb.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [1:0]        me_op_i,
   input  logic [ADDR_W-1:0] me_addr_i,
   input  logic [DATA_W-1:0] me_data_i,
   input  logic [1:0]        me_sel_i,
   input  logic              me_extend_i,
   input  logic              stall_i,
   mem_access_if.master      mem,
   output logic [DATA_W-1:0] wdata_o,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic              stall_req_o
);
   mstate_t           r_state;
   mstate_t           w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_buf;
   logic [DATA_W-1:0] w_ext;
   logic [2:0]        r_n;
   logic [2:0]        r_cnt;
   logic [1:0]        r_sel;
   logic [1:0]        r_cap_idx;
   logic              r_ext;
   logic              r_is_rd;
   logic              r_cap;
   logic              w_start;
   logic              w_issue;
   logic              w_last;

   assign w_start = ((me_op_i == MemRead) || (me_op_i == MemWrite)) && (me_sel_i != MemSelEmpty);
   assign w_issue = (r_state == MS_XFER) && mem.gnt;
   assign w_last  = w_issue && (r_cnt == r_n - 3'd1);

   always_ff @(posedge clk) begin
      if (rst) r_state <= MS_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         MS_IDLE:  if (w_start) w_next = MS_XFER;
         MS_XFER:  if (w_last)  w_next = r_is_rd ? MS_RWAIT : MS_DONE;
         MS_RWAIT: w_next = MS_DONE;
         MS_DONE:  if (!stall_i) w_next = MS_IDLE;
         default:  w_next = MS_IDLE;
      endcase
   end

   // Request fields are latched once; ex_mem is held by ctrl but may not be trusted mid-transfer.
   always_ff @(posedge clk) begin
      if ((r_state == MS_IDLE) && w_start) begin
         r_addr  <= me_addr_i;
         r_data  <= me_data_i;
         r_n     <= byte_count(me_sel_i);
         r_sel   <= me_sel_i;
         r_ext   <= me_extend_i;
         r_is_rd <= (me_op_i == MemRead);
      end
   end

   // Read data lags its address by one cycle, so the target byte lane rides along in r_cap_idx.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= 3'd0;
         r_buf     <= '0;
         r_cap     <= 1'b0;
         r_cap_idx <= 2'd0;
      end else begin
         r_cap     <= w_issue && r_is_rd;
         r_cap_idx <= r_cnt[1:0];
         if ((r_state == MS_IDLE) && w_start) begin
            r_cnt <= 3'd0;
            r_buf <= '0;
         end else begin
            if (w_issue) r_cnt <= r_cnt + 3'd1;
            if (r_cap)   r_buf[{r_cap_idx, 3'b000} +: 8] <= mem.din;
         end
      end
   end

   mem_access_load_ext #(.DATA_W(DATA_W)) u_load_ext (
      .i_buf   (r_buf),
      .i_sel   (r_sel),
      .i_ext   (r_ext),
      .o_wdata (w_ext)
   );

   always_comb begin
      mem.req     = 1'b0;
      mem.a       = '0;
      mem.dout    = 8'h00;
      mem.wr      = 1'b0;
      wdata_o     = '0;
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      stall_req_o = 1'b0;
      if (!rst) begin
         wd_o   = wd_i;
         wreg_o = wreg_i;
         case (r_state)
            MS_IDLE: begin
               wdata_o     = wdata_i;
               stall_req_o = w_start;
            end
            MS_XFER: begin
               mem.req     = 1'b1;
               stall_req_o = 1'b1;
               wdata_o     = wdata_i;
               if (mem.gnt) begin
                  mem.a = r_addr + ADDR_W'(r_cnt);
                  if (!r_is_rd) begin
                     mem.wr   = 1'b1;
                     mem.dout = r_data[{r_cnt[1:0], 3'b000} +: 8];
                  end
               end
            end
            MS_RWAIT: stall_req_o = 1'b1;
            MS_DONE:  wdata_o = r_is_rd ? w_ext : wdata_i;
            default:  wdata_o = wdata_i;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for the MEM stage with a byte-wide RAM model on the slave port.
module tb_mem_access;
   import mem_access_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] wdata_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [1:0]  me_op_i;
   logic [31:0] me_addr_i;
   logic [31:0] me_data_i;
   logic [1:0]  me_sel_i;
   logic        me_extend_i;
   logic        stall_i;
   logic [31:0] wdata_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic        stall_req_o;

   mem_access_if bus();

   mem_access dut (
      .clk         (clk),
      .rst         (rst),
      .wdata_i     (wdata_i),
      .wd_i        (wd_i),
      .wreg_i      (wreg_i),
      .me_op_i     (me_op_i),
      .me_addr_i   (me_addr_i),
      .me_data_i   (me_data_i),
      .me_sel_i    (me_sel_i),
      .me_extend_i (me_extend_i),
      .stall_i     (stall_i),
      .mem         (bus),
      .wdata_o     (wdata_o),
      .wd_o        (wd_o),
      .wreg_o      (wreg_o),
      .stall_req_o (stall_req_o)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   logic [7:0]  ram [256];
   logic [7:0]  din_nx = 8'h00;
   logic [31:0] addr_q [$];
   wr_t         wr_q [$];
   int          bad_wr = 0;

   // RAM model: read byte appears on din the cycle after its address is issued under grant.
   always @(negedge clk) begin
      if (bus.req && bus.gnt) addr_q.push_back(bus.a);
      if (bus.wr && bus.gnt)  wr_q.push_back({bus.a, bus.dout});
      if (bus.req && bus.gnt && !bus.wr) din_nx <= ram[bus.a[7:0]];
      if (bus.wr && !(bus.req && bus.gnt)) bad_wr <= bad_wr + 1;
   end

   always @(posedge clk) bus.din <= din_nx;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int i0;
   int w0;
   logic [31:0] held;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Clock until stall_req_o drops, applying one grant bit per cycle; returns stall cycles.
   task automatic run(input logic [15:0] pat, output int n);
      n = 0;
      while (n < 40) begin
         bus.gnt = pat[n[3:0]];
         #1;
         if (stall_req_o !== 1'b1) break;
         n++;
         @(posedge clk);
         #1;
      end
      bus.gnt = 1'b1;
   endtask

   task automatic go_idle();
      me_op_i = MemDisable;
      stall_i = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; wdata_i = 32'hA5A5_0001; wd_i = 5'd9; wreg_i = 1'b1;
      me_op_i = MemRead; me_addr_i = 32'h100; me_data_i = 32'h0;
      me_sel_i = MemSelWord; me_extend_i = SEXT; stall_i = 1'b0; bus.gnt = 1'b1;
      for (int k = 0; k < 256; k++) ram[k[7:0]] = k[7:0];
      ram[8'h00] = 8'h78; ram[8'h01] = 8'h56; ram[8'h02] = 8'h34; ram[8'h03] = 8'h12;
      ram[8'hFE] = 8'h11; ram[8'hFF] = 8'h22;

      step();
      chk("rst_wdata", wdata_o, 32'h0);
      chk("rst_wd", 32'(wd_o), 32'h0);
      chk("rst_wreg", 32'(wreg_o), 32'h0);
      chk("rst_stall", 32'(stall_req_o), 32'h0);
      chk("rst_req", 32'(bus.req), 32'h0);

      step();
      rst = 1'b0; me_op_i = MemDisable; wdata_i = 32'h7; wd_i = 5'd5; wreg_i = 1'b1;
      #1;
      chk("addi_wdata", wdata_o, 32'h7);
      chk("addi_wd", 32'(wd_o), 32'd5);
      chk("addi_wreg", 32'(wreg_o), 32'h1);
      chk("addi_stall", 32'(stall_req_o), 32'h0);
      chk("addi_req", 32'(bus.req), 32'h0);

      me_op_i = MemRead; me_sel_i = MemSelEmpty;
      #1;
      chk("empty_stall", 32'(stall_req_o), 32'h0);
      chk("empty_wdata", wdata_o, 32'h7);
      step();
      chk("empty_req", 32'(bus.req), 32'h0);

      // LW 0x100
      i0 = addr_q.size();
      me_op_i = MemRead; me_sel_i = MemSelWord; me_addr_i = 32'h100; wdata_i = 32'h1111_2222;
      run(16'hFFFF, cyc);
      chk("lw_stall", 32'(cyc), 32'd6);
      chk("lw_nadr", 32'(addr_q.size() - i0), 32'd4);
      chk("lw_a0", addr_q[i0], 32'h100);
      chk("lw_a1", addr_q[i0+1], 32'h101);
      chk("lw_a2", addr_q[i0+2], 32'h102);
      chk("lw_a3", addr_q[i0+3], 32'h103);
      chk("lw_wdata", wdata_o, 32'h1234_5678);
      chk("lw_done_req", 32'(bus.req), 32'h0);
      go_idle();

      // LB / LBU 0x103
      ram[8'h03] = 8'h80;
      me_op_i = MemRead; me_sel_i = MemSelByte; me_addr_i = 32'h103; me_extend_i = SEXT;
      run(16'hFFFF, cyc);
      chk("lb_stall", 32'(cyc), 32'd3);
      chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
      go_idle();
      me_op_i = MemRead; me_extend_i = UEXT;
      run(16'hFFFF, cyc);
      chk("lbu_stall", 32'(cyc), 32'd3);
      chk("lbu_wdata", wdata_o, 32'h0000_0080);
      go_idle();

      // SH 0xABCD at 0x201
      w0 = wr_q.size();
      me_op_i = MemWrite; me_sel_i = MemSelHalf; me_addr_i = 32'h201;
      me_data_i = 32'h0000_ABCD; wdata_i = 32'h55;
      run(16'hFFFF, cyc);
      chk("sh_stall", 32'(cyc), 32'd3);
      chk("sh_nwr", 32'(wr_q.size() - w0), 32'd2);
      chk("sh_a0", wr_q[w0].a, 32'h201);
      chk("sh_d0", 32'(wr_q[w0].d), 32'hCD);
      chk("sh_a1", wr_q[w0+1].a, 32'h202);
      chk("sh_d1", 32'(wr_q[w0+1].d), 32'hAB);
      chk("sh_wdata", wdata_o, 32'h55);
      go_idle();

      // LW wrapping at the top of the address space, grant withheld for two cycles
      i0 = addr_q.size();
      me_op_i = MemRead; me_sel_i = MemSelWord; me_addr_i = 32'hFFFF_FFFE; me_extend_i = SEXT;
      run(16'hFFE7, cyc);
      chk("wrap_stall", 32'(cyc), 32'd8);
      chk("wrap_a0", addr_q[i0], 32'hFFFF_FFFE);
      chk("wrap_a1", addr_q[i0+1], 32'hFFFF_FFFF);
      chk("wrap_a2", addr_q[i0+2], 32'h0);
      chk("wrap_a3", addr_q[i0+3], 32'h1);
      chk("wrap_wdata", wdata_o, 32'h5678_2211);
      go_idle();

      // SW aborted by reset after two bytes
      w0 = wr_q.size();
      me_op_i = MemWrite; me_sel_i = MemSelWord; me_addr_i = 32'h40; me_data_i = 32'hDEAD_BEEF;
      #1;
      chk("sw_idle_stall", 32'(stall_req_o), 32'h1);
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      chk("sw_rst_wr", 32'(bus.wr), 32'h0);
      chk("sw_rst_stall", 32'(stall_req_o), 32'h0);
      step();
      rst = 1'b0; me_op_i = MemDisable;
      #1;
      chk("sw_post_stall", 32'(stall_req_o), 32'h0);
      chk("sw_post_req", 32'(bus.req), 32'h0);
      step();
      step();
      chk("sw_nwr", 32'(wr_q.size() - w0), 32'd2);
      chk("sw_a0", wr_q[w0].a, 32'h40);
      chk("sw_d0", 32'(wr_q[w0].d), 32'hEF);
      chk("sw_a1", wr_q[w0+1].a, 32'h41);
      chk("sw_d1", 32'(wr_q[w0+1].d), 32'hBE);

      // LW finishing under an external stall
      me_op_i = MemRead; me_sel_i = MemSelWord; me_addr_i = 32'h100; stall_i = 1'b1;
      run(16'hFFFF, cyc);
      chk("hold_stall", 32'(cyc), 32'd6);
      chk("hold_wdata0", wdata_o, 32'h8034_5678);
      for (int k = 0; k < 3; k++) begin
         step();
         held = wdata_o;
         chk("hold_wdata", held, 32'h8034_5678);
         chk("hold_sreq", 32'(stall_req_o), 32'h0);
      end
      stall_i = 1'b0; me_op_i = MemDisable; wdata_i = 32'h99;
      step();
      chk("hold_idle_wdata", wdata_o, 32'h99);
      chk("hold_idle_stall", 32'(stall_req_o), 32'h0);

      step();
      chk("no_stray_wr", 32'(bad_wr), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
